// File: rtl/prog_load_sequencer.sv
// Program-load and run sequencer: packs a byte stream into big-endian words for
// instruction memory, then holds, releases and re-asserts core reset.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  LOAD    | accept bytes, pack words, write them to instruction memory
//  HOLD    | loading finished, core_rst held high for RST_HOLD cycles
//  RUN     | core released; ends on core_halt or after RUN_CYCLES cycles
//  DONE    | core back in reset, completion reported; left only by rst
module prog_load_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RST_HOLD   = 2,
  parameter int RUN_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  input  logic                  core_halt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_rst,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  done,
  output logic                  timeout,
  output logic                  overflow,
  output logic                  short_word
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int RUN_W  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [RUN_W-1:0]    RUN_LOAD  = RUN_W'(RUN_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_W-1:0]        r_byte_idx;
  logic [DATA_WIDTH-1:0]   r_word;
  logic [DATA_WIDTH-1:0]   w_word_ins;
  logic [HOLD_W-1:0]       r_hold_cnt;
  logic [RUN_W-1:0]        r_run_cnt;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [ADDR_WIDTH:0]     r_words_loaded;
  logic                    r_timeout;
  logic                    r_overflow;
  logic                    r_short_word;
  logic                    w_xfer;
  logic                    w_full;
  logic                    w_word_end;

  assign w_xfer     = in_valid & in_ready;
  assign w_full     = (r_words_loaded == DEPTH);
  assign w_word_end = (r_byte_idx == LAST_IDX) | in_last;

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign words_loaded = r_words_loaded;
  assign timeout      = r_timeout;
  assign overflow     = r_overflow;
  assign short_word   = r_short_word;

  // Bytes already placed stay put; bytes not yet received remain zero, which
  // gives the zero fill for a short final word for free.
  always_comb begin
    w_word_ins = r_word;
    for (int b = 0; b < BYTES; b++) begin
      if (r_byte_idx == IDX_W'(b)) begin
        w_word_ins[DATA_WIDTH-1-8*b -: 8] = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    core_rst     = 1'b1;
    done         = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (w_xfer && in_last) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        core_rst = 1'b0;
        if (core_halt || (r_run_cnt == '0)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx     <= '0;
      r_word         <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_words_loaded <= '0;
      r_overflow     <= 1'b0;
      r_short_word   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_xfer) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else if (w_word_end) begin
          r_mem_we       <= 1'b1;
          r_mem_wdata    <= w_word_ins;
          r_mem_addr     <= r_words_loaded[ADDR_WIDTH-1:0];
          r_words_loaded <= r_words_loaded + 1'b1;
          r_byte_idx     <= '0;
          r_word         <= '0;
          if (r_byte_idx != LAST_IDX) begin
            r_short_word <= 1'b1;
          end
        end else begin
          r_word     <= w_word_ins;
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end
    end
  end

  // Both timers are down-counters preloaded outside their phase, so the
  // terminal count of zero marks the last cycle of HOLD or RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= HOLD_LOAD;
      r_run_cnt  <= RUN_LOAD;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == ST_HOLD) begin
        if (r_hold_cnt != '0) begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end
      end else begin
        r_hold_cnt <= HOLD_LOAD;
      end

      if (r_state == ST_RUN) begin
        if (r_run_cnt != '0) begin
          r_run_cnt <= r_run_cnt - 1'b1;
        end
        if (!core_halt && (r_run_cnt == '0)) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_run_cnt <= RUN_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Scoreboard bench for prog_load_sequencer: expected memory writes are queued
// from a byte-list model and popped by an independent write monitor.
module tb_prog_load_sequencer;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int RH    = 2;
  localparam int RC    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int BPW   = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            in_last;
  logic            core_halt;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            core_rst;
  logic [AW:0]     words_loaded;
  logic            done;
  logic            timeout;
  logic            overflow;
  logic            short_word;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  prog_load_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RST_HOLD  (RH),
    .RUN_CYCLES(RC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .core_halt   (core_halt),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .words_loaded(words_loaded),
    .done        (done),
    .timeout     (timeout),
    .overflow    (overflow),
    .short_word  (short_word)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_wdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_short_word"}, 64'(short_word), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    core_halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals({tag, "_in_rst"});
    chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals({tag, "_after_rst"});
  endtask

  // Reference model: split the byte list into words of BPW bytes (big-endian,
  // zero-filled tail), keep only what fits in memory.
  task automatic push_expected(input logic [7:0] b[$], input bit with_last);
    int n = b.size();
    for (int w = 0; w < DEPTH && w * BPW < n; w++) begin
      logic [DW-1:0] d = '0;
      if (!with_last && (w + 1) * BPW > n) break;
      for (int k = 0; k < BPW; k++) begin
        if (w * BPW + k < n) d[DW-1-8*k -: 8] = b[w*BPW+k];
      end
      exp_q.push_back('{addr: AW'(w), data: d});
    end
  endtask

  // Drives the bytes with random idle gaps carrying junk in_data/in_last.
  task automatic send_bytes(input logic [7:0] b[$], input bit with_last);
    for (int i = 0; i < b.size(); i++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b[i];
      in_last  = with_last && (i == b.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full load + run. halt_at: RUN cycle (1-based) on which core_halt is
  // raised, 0 for none. abort_at: RUN cycle on which rst is applied, 0 for none.
  task automatic run_test(input string tag, input logic [7:0] b[$], input int halt_at,
                          input int abort_at);
    int  n          = b.size();
    int  exp_words  = ((n + BPW - 1) / BPW > DEPTH) ? DEPTH : (n + BPW - 1) / BPW;
    bit  exp_short  = (n % BPW != 0) && ((n - 1) / BPW < DEPTH);
    bit  exp_ovf    = n > DEPTH * BPW;
    bit  halted     = (halt_at >= 1) && (halt_at <= RC);
    int  exp_run    = halted ? halt_at : RC;
    int  runcnt     = 0;
    int  holdcnt    = 0;
    bit  seen_done  = 1'b0;

    push_expected(b, 1'b1);
    send_bytes(b, 1'b1);

    for (int cyc = 0; cyc < 100; cyc++) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      if (core_rst === 1'b0) begin
        runcnt++;
        if (abort_at != 0 && runcnt == abort_at) begin
          do_reset({tag, "_abort_run"});
          return;
        end
        core_halt = (runcnt == halt_at);
      end else if (in_ready === 1'b0) begin
        holdcnt++;
        core_halt = 1'($urandom);
      end
      @(negedge clk);
    end
    core_halt = 1'b0;

    chk({tag, "_done_reached"}, 64'(seen_done), 64'd1);
    chk({tag, "_hold_cycles"}, 64'(holdcnt), 64'(RH));
    chk({tag, "_run_cycles"}, 64'(runcnt), 64'(exp_run));
    chk({tag, "_timeout"}, 64'(timeout), 64'(!halted));
    chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_words));
    chk({tag, "_short_word"}, 64'(short_word), 64'(exp_short));
    chk({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, "_last_addr"}, 64'(mem_addr), 64'(exp_words - 1));
    chk({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_sticky"}, 64'(done), 64'd1);
    chk({tag, "_no_we_in_done"}, 64'(mem_we), 64'd0);
  endtask

  initial begin
    logic [7:0] b[$];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    core_halt = 1'b0;

    do_reset("init");

    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_test("two_words", b, 0, 0);

    do_reset("r1");
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_test("short", b, 4, 0);

    do_reset("r2");
    b.delete();
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    run_test("overflow", b, RC, 0);

    do_reset("r3");
    b = '{8'hDE, 8'hAD, 8'hBE};
    push_expected(b, 1'b0);
    send_bytes(b, 1'b0);
    do_reset("abort_load");

    b = '{8'hC0, 8'hFF, 8'hEE, 8'h11};
    run_test("pre_abort", b, 0, 3);

    b = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_test("fresh", b, 0, 0);

    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(1, 22);
      do_reset("rnd_rst");
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      run_test("rnd", b, $urandom_range(0, RC + 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
